ps2_rx_hex: RTL
===============

Name: ps2_rx_hex

Overview:
- PS/2 keyboard receiver on the clk108 domain; feeds the seven-segment `hex` driver through its `en`/`val`/`dig` write interface.
- Oversamples the device-driven ps2_clk and ps2_dat lines and deglitches the clock.
- Deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop) and presents the received byte.
- Writes each received byte as two nibbles to consecutive hex digits.

Parameters:
- FILT_LEN, 8, consecutive identical ps2_clk samples required to change the filtered clock level (2..16).
- TIMEOUT, 216000, cycles without a filtered falling edge before a partial frame is aborted (2 ms at 108 MHz; counter width 18 bits).
- DIG_LO, 0, hex digit index that receives the low nibble. The high nibble goes to DIG_LO+1, mod 4.

Ports:
- clk  in  1  system clock (clk108).
- rst_n  in  1  synchronous reset, active-low.
- ps2_clk  in  1  PS/2 clock line (asynchronous).
- ps2_dat  in  1  PS/2 data line (asynchronous).
- data  out  8  last correctly received byte.
- valid  out  1  one-cycle strobe when data updates.
- err  out  1  one-cycle strobe on parity, stop or timeout error.
- busy  out  1  high while a frame or a hex write sequence is in progress (state != IDLE).
- hex_en  out  1  hex digit write enable.
- hex_val  out  4  nibble to write.
- hex_dig  out  2  digit index to write.

Behaviour:
- Reset, when rst_n is low at a clk edge:
  - data=0x00; valid=0; err=0; busy=0; hex_en=0; hex_val=0; hex_dig=0.
  - Filtered clock = 1, synchronisers = 1, FSM = IDLE, timeout counter = 0.
  - Reset mid-frame discards the partial frame and produces no valid and no err.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-FF synchroniser.
  - Filter: shift register of FILT_LEN synchronised clock samples. The filtered level changes only when all samples equal the opposite level.
  - A bit is sampled from synchronised ps2_dat in the cycle the filtered clock goes 1->0 (the "edge").
- FSM states:
  - IDLE: on an edge with dat=0 -> DATA (bit count 0). On an edge with dat=1 -> stay in IDLE, no err.
  - DATA: shift in 8 edges, LSB first -> PARITY.
  - PARITY: on an edge, store the parity bit -> STOP.
  - STOP: on edge cycle E, check that dat=1 and that (popcount(data bits)+parity) is odd.
    - Both checks pass -> HEX_LO.
    - Either check fails -> ERR_ST.
  - HEX_LO (cycle E+1): data<=byte; valid=1; hex_en=1; hex_dig=DIG_LO; hex_val=byte[3:0] -> HEX_HI.
  - HEX_HI (cycle E+2): hex_en=1; hex_dig=DIG_LO+1 (2-bit wrap); hex_val=byte[7:4] -> IDLE.
  - ERR_ST (cycle E+1): err=1; data unchanged; no hex write -> IDLE.
- Outputs are registered.
- valid, err and hex_en are low in every other cycle.
- hex_val and hex_dig hold their last values when hex_en=0.
- Timeout:
  - Counter clears in IDLE and on every edge; it increments in DATA, PARITY and STOP.
  - Reaching TIMEOUT-1 -> ERR_ST (err pulse next cycle), then IDLE. The partial frame is discarded.
- Edges arriving in HEX_LO, HEX_HI or ERR_ST are ignored. A legal PS/2 bit period is at least 60 µs, so a real edge cannot occur there.
- Back-to-back frames are accepted with no gap requirement beyond PS/2 timing.

Test Plan:
- Reset, then ps2_clk at 10 kHz (half-period 5400 cycles) sending 0x1C with parity 0 and stop 1. Required response:
  - valid for 1 cycle with data=0x1C.
  - Next two cycles: hex_en=1 with (dig 0, val 0xC), then (dig 1, val 0x1).
  - err never asserted.
- Frame 0xF0 with parity 1, followed directly by a frame 0x1C. Required response: two valid pulses, data ends at 0x1C, four hex writes (0x0,0xF,0xC,0x1).
- Frame 0x1C with parity 1 -> err pulse once, no valid, no hex_en, data keeps its previous value. Separately, a frame with stop=0 -> err only.
- Glitch test: 3-cycle low pulses on ps2_clk between legal bits, with FILT_LEN=8 -> no extra bit sampled; frame 0x5A received correctly.
- Timeout test: send start + 4 data bits, then hold ps2_clk high. Required response:
  - err pulses exactly TIMEOUT cycles after the last edge (±2 cycles of synchroniser/filter delay).
  - busy then goes low.
  - A following frame 0x5A gives valid with data=0x5A.
- Mid-frame reset: pull rst_n low for 1 cycle after 6 bits -> all outputs 0, no err. The remaining bits are a stop-less tail and cause no valid; the next full frame 0x29 gives valid with data=0x29.

Source files
------------

// File: rtl/ps2_rx_hex.sv
// PS/2 keyboard receiver: conditions the device-driven lines, deframes 11-bit
// frames and writes each good byte as two nibbles into the seven-segment driver.
module ps2_rx_hex #(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 216000,
  parameter int DIG_LO   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       valid,
  output logic       err,
  output logic       busy,
  output logic       hex_en,
  output logic [3:0] hex_val,
  output logic [1:0] hex_dig
);

  localparam int            TW      = 18;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0]    DIG_A   = 2'(DIG_LO);
  localparam logic [1:0]    DIG_B   = DIG_A + 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    HEX_LO,
    HEX_HI,
    ERR_ST
  } state_t;

  logic                clk_s1, clk_s2;
  logic                dat_s1, dat_s2;
  logic [FILT_LEN-1:0] filt_sh;
  logic                clk_f;
  logic                fall;
  logic                tmo;

  state_t              state;
  logic [2:0]          bit_cnt;
  logic [7:0]          shreg;
  logic                par;
  logic [TW-1:0]       to_cnt;

  // Idle PS/2 lines are high, so synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_sh <= '1;
      clk_f   <= 1'b1;
    end else begin
      filt_sh <= {filt_sh[FILT_LEN-2:0], clk_s2};
      if (filt_sh == '0) begin
        clk_f <= 1'b0;
      end else if (filt_sh == '1) begin
        clk_f <= 1'b1;
      end
    end
  end

  assign fall = clk_f && (filt_sh == '0);
  assign tmo  = (to_cnt == TO_LAST);
  assign busy = (state != IDLE);

  // valid/err/hex_en are single-cycle strobes; hex_val/hex_dig hold between writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      par     <= 1'b0;
      to_cnt  <= '0;
      data    <= 8'h00;
      valid   <= 1'b0;
      err     <= 1'b0;
      hex_en  <= 1'b0;
      hex_val <= 4'h0;
      hex_dig <= 2'd0;
    end else begin
      valid  <= 1'b0;
      err    <= 1'b0;
      hex_en <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (fall && !dat_s2) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
          end
        end
        DATA: begin
          if (fall) begin
            to_cnt  <= '0;
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end else if (tmo) begin
            state <= ERR_ST;
            err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        PARITY: begin
          if (fall) begin
            to_cnt <= '0;
            par    <= dat_s2;
            state  <= STOP;
          end else if (tmo) begin
            state <= ERR_ST;
            err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        STOP: begin
          if (fall) begin
            to_cnt <= '0;
            // Odd parity: XOR over the byte and parity bit must be 1.
            if (dat_s2 && (^{shreg, par})) begin
              state   <= HEX_LO;
              data    <= shreg;
              valid   <= 1'b1;
              hex_en  <= 1'b1;
              hex_dig <= DIG_A;
              hex_val <= shreg[3:0];
            end else begin
              state <= ERR_ST;
              err   <= 1'b1;
            end
          end else if (tmo) begin
            state <= ERR_ST;
            err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        HEX_LO: begin
          state   <= HEX_HI;
          hex_en  <= 1'b1;
          hex_dig <= DIG_B;
          hex_val <= data[7:4];
        end
        HEX_HI: begin
          state <= IDLE;
        end
        ERR_ST: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
